display_mode_controller: RTL

- Sequences the seven-segment display driver and owns the user-editing path for setting the time.
- Decodes one-cycle button pulses into the display mode and the blinking digit location.
- Holds editable BCD hours/minutes digits during setup, with range limits enforced.
- Generates the digit-scan tick and the blink phase, and issues a one-cycle load strobe to the timekeeper when setup is committed.

---
 rtl/display_mode_controller_if.sv | 44 ++++
 rtl/display_mode_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_controller_if.sv
// ---------------------------------------------------------------------------
// display_mode_controller_if
// Purpose : groups the button pulses, the timekeeper's current time and the
//           controller's display/setup outputs into one bundle.
// Signals : btn_set/btn_mode/btn_next/btn_inc  one-cycle debounced pulses
//           cur_hu/cur_hl/cur_mu/cur_ml        current BCD time (4 bits each)
//           mode[1:0], location[1:0]           display mode, edited digit
//           set_hu/set_hl/set_mu/set_ml        edited BCD digits
//           load_time, blink_on, scan_tick     strobes and blink phase
// Modports: master = button/timekeeper side, slave = the controller.
// ---------------------------------------------------------------------------
interface display_mode_controller_if;
  logic       btn_set;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_inc;
  logic [3:0] cur_hu;
  logic [3:0] cur_hl;
  logic [3:0] cur_mu;
  logic [3:0] cur_ml;
  logic [1:0] mode;
  logic [1:0] location;
  logic [3:0] set_hu;
  logic [3:0] set_hl;
  logic [3:0] set_mu;
  logic [3:0] set_ml;
  logic       load_time;
  logic       blink_on;
  logic       scan_tick;

  modport master (
    output btn_set, btn_mode, btn_next, btn_inc,
    output cur_hu, cur_hl, cur_mu, cur_ml,
    input  mode, location, set_hu, set_hl, set_mu, set_ml,
    input  load_time, blink_on, scan_tick
  );

  modport slave (
    input  btn_set, btn_mode, btn_next, btn_inc,
    input  cur_hu, cur_hl, cur_mu, cur_ml,
    output mode, location, set_hu, set_hl, set_mu, set_ml,
    output load_time, blink_on, scan_tick
  );
endinterface

// File: rtl/display_mode_controller.sv
// ---------------------------------------------------------------------------
// display_mode_controller
// Purpose : run/setup mode sequencing for the seven-segment clock display,
//           BCD time editing with range limits, digit-scan tick, blink phase
//           and the one-cycle load strobe to the timekeeper on commit.
// Ports   : clk    system clock
//           rst_n  asynchronous active-low reset
//           bus    display_mode_controller_if.slave (buttons, cur_*, outputs)
// Params  : SCAN_DIV      clk cycles between scan_tick pulses
//           BLINK_DIV     clk cycles per blink half-period
//           TIMEOUT_HALF  idle blink half-periods before auto-exit
// Option  : DISPLAY_MODE_CONTROLLER_AUTO_EXIT_EN -- when defined, SETUP is
//           abandoned (no load) after TIMEOUT_HALF idle blink half-periods.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_SETUP   | editing set_* digits, location selects the blinking digit
// ST_TIME24  | run, 24-hour display
// ST_SECONDS | run, seconds display
// ST_TIME12  | run, 12-hour display
// ---------------------------------------------------------------------------
module display_mode_controller #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_DIV    = 25000000,
  parameter int TIMEOUT_HALF = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  display_mode_controller_if.slave      bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Encoding doubles as the mode output value.
  typedef enum logic [1:0] {
    ST_SETUP   = 2'b00,
    ST_TIME24  = 2'b01,
    ST_SECONDS = 2'b10,
    ST_TIME12  = 2'b11
  } state_t;

  state_t               r_state;
  state_t               r_saved;
  logic [1:0]           r_location;
  logic [3:0]           r_set_hu;
  logic [3:0]           r_set_hl;
  logic [3:0]           r_set_mu;
  logic [3:0]           r_set_ml;
  logic                 r_load_time;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_blink_on;
  logic [SCAN_W-1:0]    r_scan_cnt;
  logic                 r_scan_tick;

`ifdef DISPLAY_MODE_CONTROLLER_AUTO_EXIT_EN
  localparam int IDLE_W = (TIMEOUT_HALF > 1) ? $clog2(TIMEOUT_HALF + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_HALF - 1);
  logic [IDLE_W-1:0]    r_idle_cnt;
`endif

  state_t               w_run_next;
  logic                 w_scan_wrap;
  logic                 w_blink_wrap;
  logic                 w_edit;
  logic [3:0]           w_hl_limit;
  logic [3:0]           w_hu_inc;
  logic [3:0]           w_hl_inc;
  logic [3:0]           w_mu_inc;
  logic [3:0]           w_ml_inc;
  logic [3:0]           w_hl_after_hu;

  always_comb begin
    w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
    w_blink_wrap = (r_blink_cnt == BLINK_LAST);
    // btn_mode outranks next/inc even though it does nothing in SETUP.
    w_edit       = !bus.btn_mode && (bus.btn_next || bus.btn_inc);

    w_run_next = ST_TIME24;
    case (r_state)
      ST_TIME24:  w_run_next = ST_SECONDS;
      ST_SECONDS: w_run_next = ST_TIME12;
      default:    w_run_next = ST_TIME24;
    endcase

    // ">=" also recovers gracefully from an out-of-range loaded digit.
    w_hl_limit    = (r_set_hu == 4'd2) ? 4'd3 : 4'd9;
    w_hu_inc      = (r_set_hu >= 4'd2) ? 4'd0 : r_set_hu + 4'd1;
    w_hl_inc      = (r_set_hl >= w_hl_limit) ? 4'd0 : r_set_hl + 4'd1;
    w_mu_inc      = (r_set_mu >= 4'd5) ? 4'd0 : r_set_mu + 4'd1;
    w_ml_inc      = (r_set_ml >= 4'd9) ? 4'd0 : r_set_ml + 4'd1;
    // Stepping hours into the 20s must not leave an illegal 24..29.
    w_hl_after_hu = ((w_hu_inc == 4'd2) && (r_set_hl > 4'd3)) ? 4'd3 : r_set_hl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_TIME24;
      r_saved     <= ST_TIME24;
      r_location  <= 2'd0;
      r_set_hu    <= 4'd0;
      r_set_hl    <= 4'd0;
      r_set_mu    <= 4'd0;
      r_set_ml    <= 4'd0;
      r_load_time <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_scan_cnt  <= '0;
      r_scan_tick <= 1'b0;
`ifdef DISPLAY_MODE_CONTROLLER_AUTO_EXIT_EN
      r_idle_cnt  <= '0;
`endif
    end else begin
      r_load_time <= 1'b0;

      if (w_scan_wrap) begin
        r_scan_cnt  <= '0;
        r_scan_tick <= 1'b1;
      end else begin
        r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
        r_scan_tick <= 1'b0;
      end

      // Free-running; the edit/entry paths below override with a restart.
      if (w_blink_wrap) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end

      case (r_state)
        ST_SETUP: begin
          if (bus.btn_set) begin
            r_state     <= r_saved;
            r_location  <= 2'd0;
            r_load_time <= 1'b1;
          end else if (w_edit) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
`ifdef DISPLAY_MODE_CONTROLLER_AUTO_EXIT_EN
            r_idle_cnt  <= '0;
`endif
            if (bus.btn_next) begin
              r_location <= r_location + 2'd1;
            end else begin
              case (r_location)
                2'd0: begin
                  r_set_hu <= w_hu_inc;
                  r_set_hl <= w_hl_after_hu;
                end
                2'd1:    r_set_hl <= w_hl_inc;
                2'd2:    r_set_mu <= w_mu_inc;
                default: r_set_ml <= w_ml_inc;
              endcase
            end
          end
`ifdef DISPLAY_MODE_CONTROLLER_AUTO_EXIT_EN
          else if (w_blink_wrap) begin
            if (r_idle_cnt == IDLE_LAST) begin
              r_state    <= r_saved;
              r_location <= 2'd0;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end
`endif
        end
        default: begin
          if (bus.btn_set) begin
            r_saved     <= r_state;
            r_state     <= ST_SETUP;
            r_location  <= 2'd0;
            r_set_hu    <= bus.cur_hu;
            r_set_hl    <= bus.cur_hl;
            r_set_mu    <= bus.cur_mu;
            r_set_ml    <= bus.cur_ml;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
`ifdef DISPLAY_MODE_CONTROLLER_AUTO_EXIT_EN
            r_idle_cnt  <= '0;
`endif
          end else if (bus.btn_mode) begin
            r_state <= w_run_next;
          end
        end
      endcase
    end
  end

  assign bus.mode      = r_state;
  assign bus.location  = r_location;
  assign bus.set_hu    = r_set_hu;
  assign bus.set_hl    = r_set_hl;
  assign bus.set_mu    = r_set_mu;
  assign bus.set_ml    = r_set_ml;
  assign bus.load_time = r_load_time;
  assign bus.blink_on  = r_blink_on;
  assign bus.scan_tick = r_scan_tick;

endmodule
